// File: rtl/keypad_time_encoder.sv
// Keypad entry for the countdown timer: synchronises and debounces one-hot key presses,
// then shifts each accepted key in from the right as BCD digits (microwave-style entry).
module keypad_time_encoder #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic       clear_entry,
  input  logic [9:0] keypad,
  output logic [3:0] Minutos,
  output logic [3:0] DezenaSegundos,
  output logic [3:0] UnidadeSegundos,
  output logic       digit_strobe,
  output logic       key_error,
  output logic       time_valid
);

  localparam int CNT_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, DEBOUNCE, WAIT_REL} state_t;

  state_t           state, state_next;
  logic [9:0]       sync1, ks;
  logic [9:0]       cap, cap_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             accept;
  logic [9:0]       accept_code;
  logic             key_onehot;
  logic [3:0]       key_digit;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1 <= '0;
      ks    <= '0;
    end else begin
      sync1 <= keypad;
      ks    <= sync1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      cap   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cap   <= cap_next;
      cnt   <= cnt_next;
    end
  end

  // cnt holds how many identical samples of cap have been seen so far
  always_comb begin
    state_next  = state;
    cap_next    = cap;
    cnt_next    = cnt;
    accept      = 1'b0;
    accept_code = cap;
    case (state)
      IDLE: begin
        if (ks != 10'd0) begin
          cap_next = ks;
          cnt_next = CNT_W'(1);
          if (DEBOUNCE_CYCLES == 1) begin
            accept      = 1'b1;
            accept_code = ks;
            state_next  = WAIT_REL;
          end else begin
            state_next = DEBOUNCE;
          end
        end
      end
      DEBOUNCE: begin
        if (ks != cap) begin
          state_next = IDLE;
        end else begin
          cnt_next = cnt + CNT_W'(1);
          if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            accept     = 1'b1;
            state_next = WAIT_REL;
          end
        end
      end
      WAIT_REL: begin
        if (ks == 10'd0) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    key_onehot = (accept_code != 10'd0) &&
                 ((accept_code & (accept_code - 10'd1)) == 10'd0);
    key_digit  = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (accept_code[i]) key_digit = 4'(i);
    end
  end

  // clear_entry outranks a coincident accept; the FSM still advances on its own
  always_ff @(posedge clock) begin
    if (reset) begin
      Minutos         <= 4'd0;
      DezenaSegundos  <= 4'd0;
      UnidadeSegundos <= 4'd0;
      digit_strobe    <= 1'b0;
      key_error       <= 1'b0;
      time_valid      <= 1'b1;
    end else begin
      digit_strobe <= 1'b0;
      key_error    <= 1'b0;
      if (clear_entry) begin
        Minutos         <= 4'd0;
        DezenaSegundos  <= 4'd0;
        UnidadeSegundos <= 4'd0;
        time_valid      <= 1'b1;
      end else if (accept) begin
        if (!key_onehot) begin
          key_error <= 1'b1;
        end else if (enable) begin
          Minutos         <= DezenaSegundos;
          DezenaSegundos  <= UnidadeSegundos;
          UnidadeSegundos <= key_digit;
          digit_strobe    <= 1'b1;
          time_valid      <= (UnidadeSegundos <= 4'd5);
        end
      end
    end
  end

endmodule
